// File: rtl/fetch_pkg.sv
// Shared widths, reset PC and the output queue entry for the fetch stage.
package fetch_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic [DEF_ADDR_W-1:0] RESET_PC = 32'h0000_3000;

  // One decoded-side entry; err marks a misaligned fetch carrying no instruction.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] instr;
    logic [DEF_ADDR_W-1:0] pc;
    logic                  err;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with synchronous clear and an occupancy count.
// Clear has priority over push and pop. Depth need not be a power of two.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)   // derived, leave at default
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pointer and count bookkeeping.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage array; no reset needed since count gates every read.
  always_ff @(posedge Clk) begin
    if (push && !clr) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

  // Upstream credit logic must never push into a full queue or pop an empty one.
  always_ff @(posedge Clk) begin
    if (Rst_n && !clr) begin
      assert (!(push && !pop && count == CW'(DEPTH)));
      assert (!(pop && count == '0));
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC handshake in, in-order memory requests out, and a
// registered output queue of {instr, pc, err} for decode. Flush drops all
// queued work and marks still-outstanding responses for discard.
// The entry struct is fixed at the package widths; ADDR_W/DATA_W must match.
module inst_fetch import fetch_pkg::*; #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] Pc_in,
  input  logic              Pc_valid,
  output logic              Pc_ready,
  output logic              Imem_req,
  output logic [ADDR_W-1:0] Imem_addr,
  input  logic              Imem_gnt,
  input  logic              Imem_rvalid,
  input  logic [DATA_W-1:0] Imem_rdata,
  input  logic              Flush,
  output logic              Inst_valid,
  input  logic              Inst_ready,
  output logic [DATA_W-1:0] Inst_out,
  output logic [ADDR_W-1:0] Inst_pc,
  output logic              Inst_err
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  logic [CW-1:0] inflight;
  logic [CW-1:0] discard_cnt;
  logic [CW-1:0] out_count;
  logic [CW-1:0] pend_count;
  logic          credit_ok;
  logic          aligned;
  logic          base_ok;
  logic          grant;
  logic          mis_take;
  logic          resp_keep;
  logic          out_push;
  logic          out_pop;
  logic [ADDR_W-1:0] pend_pc;
  fetch_entry_t  out_wdata;
  fetch_entry_t  head;

  // In-flight reads and queued entries share one credit pool of DEPTH.
  assign credit_ok = ({1'b0, inflight} + {1'b0, out_count}) < DEPTH_W;
  assign aligned   = (Pc_in[1:0] == 2'b00);
  assign base_ok   = Rst_n & Pc_valid & credit_ok & ~Flush;

  assign Imem_req  = base_ok & aligned;
  assign Imem_addr = Pc_in;
  assign grant     = Imem_req & Imem_gnt;

  // A misaligned PC waits for older reads to drain so it lands in program order.
  assign mis_take  = base_ok & ~aligned & (inflight == '0);
  assign Pc_ready  = grant | mis_take;

  assign resp_keep = Imem_rvalid & (discard_cnt == '0) & ~Flush;
  assign out_push  = resp_keep | mis_take;
  assign out_wdata = resp_keep ? '{instr: Imem_rdata, pc: pend_pc, err: 1'b0}
                               : '{instr: '0,         pc: Pc_in,   err: 1'b1};

  assign Inst_valid = (out_count != '0);
  assign out_pop    = Inst_valid & Inst_ready & ~Flush;
  assign Inst_out   = Inst_valid ? head.instr : '0;
  assign Inst_pc    = Inst_valid ? head.pc    : RESET_PC;
  assign Inst_err   = Inst_valid ? head.err   : 1'b0;

  // Outstanding-read and pending-discard counters.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      inflight    <= '0;
      discard_cnt <= '0;
    end else begin
      inflight <= inflight + CW'(grant) - CW'(Imem_rvalid);
      if (Flush)
        discard_cnt <= inflight - CW'(Imem_rvalid);
      else if (Imem_rvalid && discard_cnt != '0)
        discard_cnt <= discard_cnt - CW'(1);
    end
  end

  // Every kept read has a pending PC; discarded ones do not.
  always_ff @(posedge Clk) begin
    if (Rst_n) begin
      assert (pend_count == inflight - discard_cnt);
      assert (!(Imem_rvalid && inflight == '0));
    end
  end

  fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_pend_q (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .clr   (Flush),
    .push  (grant),
    .wdata (Pc_in),
    .pop   (resp_keep),
    .rdata (pend_pc),
    .count (pend_count)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_out_q (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .clr   (Flush),
    .push  (out_push),
    .wdata (out_wdata),
    .pop   (out_pop),
    .rdata (head),
    .count (out_count)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios then randomized traffic, all
// checked against a queue-based program-order model and a latency memory.
module tb_inst_fetch;

  localparam int DEPTH = 2;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [31:0] Pc_in;
  logic        Pc_valid;
  logic        Pc_ready;
  logic        Imem_req;
  logic [31:0] Imem_addr;
  logic        Imem_gnt;
  logic        Imem_rvalid;
  logic [31:0] Imem_rdata;
  logic        Flush;
  logic        Inst_valid;
  logic        Inst_ready;
  logic [31:0] Inst_out;
  logic [31:0] Inst_pc;
  logic        Inst_err;

  inst_fetch #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Pc_in(Pc_in), .Pc_valid(Pc_valid), .Pc_ready(Pc_ready),
    .Imem_req(Imem_req), .Imem_addr(Imem_addr), .Imem_gnt(Imem_gnt),
    .Imem_rvalid(Imem_rvalid), .Imem_rdata(Imem_rdata), .Flush(Flush),
    .Inst_valid(Inst_valid), .Inst_ready(Inst_ready), .Inst_out(Inst_out),
    .Inst_pc(Inst_pc), .Inst_err(Inst_err)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;

  mreq_t       memq[$];
  logic [64:0] exp_q[$];
  int          fifo_m, disc_m;
  int          cyc, acc_cyc, npop;
  int          n_chk, n_pass;
  int          lat_fix;
  bit          lat_rand;
  bit          last_acc;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h3000: return 32'h2008_0001;
      32'h3004: return 32'h2009_0002;
      32'h3008: return 32'h0109_5020;
      default:  return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] a;
    a = 32'h3000 + ($urandom_range(0, 255) << 2);
    if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  // Compare this cycle's combinational outputs against the handshake rules,
  // then apply the events that the coming edge will perform.
  task automatic observe();
    int  inflight_m;
    bit  credit, aligned, exp_req, exp_rdy;
    logic [64:0] e;
    inflight_m = memq.size() + (Imem_rvalid ? 1 : 0);
    credit     = (inflight_m + fifo_m) < DEPTH;
    aligned    = (Pc_in[1:0] == 2'b00);
    exp_req    = Pc_valid && credit && !Flush && aligned;
    exp_rdy    = aligned ? (exp_req && Imem_gnt)
                         : (Pc_valid && credit && !Flush && inflight_m == 0);
    chk("imem_req", Imem_req, exp_req);
    chk("pc_ready", Pc_ready, exp_rdy);
    chk("inst_valid", Inst_valid, fifo_m > 0);
    if (Imem_req) chk("imem_addr", Imem_addr, Pc_in);
    last_acc = Pc_valid && Pc_ready;
    if (last_acc) acc_cyc = cyc;
    if (Imem_req && Imem_gnt)
      memq.push_back('{addr: Pc_in, due: cyc + (lat_rand ? int'($urandom_range(1, 3)) : lat_fix)});
    if (Flush) begin
      exp_q.delete();
      fifo_m = 0;
      disc_m = memq.size();
    end else begin
      if (Inst_valid && Inst_ready) begin
        if (exp_q.size() == 0) chk("inst_unexpected", Inst_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("inst_entry", {Inst_out, Inst_pc, Inst_err}, e);
        end
        if (fifo_m > 0) fifo_m--;
        npop++;
      end
      if (Imem_rvalid) begin
        if (disc_m > 0) disc_m--;
        else fifo_m++;
      end
      if (last_acc) begin
        if (aligned) exp_q.push_back({memword(Pc_in), Pc_in, 1'b0});
        else begin
          exp_q.push_back({32'h0, Pc_in, 1'b1});
          fifo_m++;
        end
      end
    end
  endtask

  task automatic mem_drive();
    mreq_t r;
    Imem_rvalid = 1'b0;
    Imem_rdata  = $urandom;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      r = memq.pop_front();
      Imem_rvalid = 1'b1;
      Imem_rdata  = memword(r.addr);
    end
  endtask

  // Called at posedge+1 with inputs set; returns at the next posedge+1.
  task automatic tick();
    #1;
    observe();
    @(posedge Clk); #1;
    cyc++;
    mem_drive();
  endtask

  task automatic feed(input logic [31:0] a);
    int n;
    Pc_valid = 1'b1;
    Pc_in    = a;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 50);
    if (!last_acc) chk("feed_timeout", last_acc, 1);
    Pc_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    Pc_valid = 1'b0;
    Flush = 1'b0;
    Inst_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || memq.size() != 0 || Imem_rvalid || fifo_m != 0) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic clear_model();
    memq.delete();
    exp_q.delete();
    fifo_m = 0;
    disc_m = 0;
    Imem_rvalid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0;
    bit stall_acc, flush_prev;
    n_chk = 0; n_pass = 0; cyc = 0; npop = 0; acc_cyc = 0;
    lat_fix = 1; lat_rand = 0; last_acc = 0;
    clear_model();
    Rst_n = 1'b0; Pc_in = 32'h3000; Pc_valid = 1'b1; Imem_gnt = 1'b0;
    Imem_rdata = '0; Flush = 1'b0; Inst_ready = 1'b0;
    #1;
    chk("rst_pc_ready", Pc_ready, 0);
    chk("rst_imem_req", Imem_req, 0);
    chk("rst_inst_valid", Inst_valid, 0);
    chk("rst_inst_out", Inst_out, 32'h0);
    chk("rst_inst_pc", Inst_pc, 32'h3000);
    chk("rst_inst_err", Inst_err, 0);
    Pc_valid = 1'b0;
    @(posedge Clk); @(posedge Clk); #3 Rst_n = 1'b1;
    @(posedge Clk); #1;
    Imem_gnt = 1'b1;

    // Straight-line fetch of three instructions.
    n0 = npop; Inst_ready = 1'b1;
    feed(32'h3000); feed(32'h3004); feed(32'h3008);
    drain();
    chk("t1_pops", npop - n0, 3);

    // Decode stalled: credit exhausts after two, frees the cycle after a pop.
    Inst_ready = 1'b0;
    feed(32'h3000); feed(32'h3004);
    Pc_valid = 1'b1; Pc_in = 32'h3008; stall_acc = 0;
    for (int i = 0; i < 5; i++) begin tick(); stall_acc |= last_acc; end
    chk("t2_stalled", stall_acc, 0);
    Inst_ready = 1'b1;
    tick();
    chk("t2_pop_cycle_acc", last_acc, 0);
    tick();
    chk("t2_acc_after_pop", last_acc, 1);
    drain();

    // Flush with two reads outstanding; both responses must be dropped.
    n0 = npop; lat_fix = 3;
    feed(32'h3000); feed(32'h3004);
    Flush = 1'b1; Pc_valid = 1'b1; Pc_in = 32'h3040;
    tick();
    Flush = 1'b0;
    feed(32'h3040);
    drain();
    chk("t3_pops", npop - n0, 1);

    // Flush coinciding with a response and a pop.
    lat_fix = 1;
    feed(32'h3000); feed(32'h3004);
    chk("t4_setup_valid", Inst_valid, 1);
    chk("t4_setup_rvalid", Imem_rvalid, 1);
    n0 = npop;
    Flush = 1'b1; Inst_ready = 1'b1;
    tick();
    Flush = 1'b0;
    chk("t4_empty", Inst_valid, 0);
    feed(32'h3040);
    drain();
    chk("t4_pops", npop - n0, 1);

    // Misaligned PC waits behind an in-flight read, then follows it in order.
    lat_fix = 3;
    feed(32'h3000);
    n0 = acc_cyc;
    Pc_valid = 1'b1; Pc_in = 32'h3002;
    for (int i = 0; i < 20 && !(i > 0 && last_acc); i++) tick();
    Pc_valid = 1'b0;
    chk("t5_accept_cycle", acc_cyc, n0 + 3 + 1);
    chk("t5_mis_head", {Inst_valid, Inst_out, Inst_pc, Inst_err}, {1'b1, 32'h0, 32'h3002, 1'b1});
    drain();

    // Asynchronous reset with entries queued.
    lat_fix = 1; Inst_ready = 1'b0;
    feed(32'h3000); feed(32'h3004);
    tick(); tick();
    chk("t6_pre_valid", Inst_valid, 1);
    #2 Rst_n = 1'b0;
    #1;
    chk("t6_inst_valid", Inst_valid, 0);
    chk("t6_inst_pc", Inst_pc, 32'h3000);
    chk("t6_inst_out", Inst_out, 32'h0);
    chk("t6_pc_ready", Pc_ready, 0);
    clear_model();
    @(posedge Clk); #3 Rst_n = 1'b1;
    @(posedge Clk); #1;
    n0 = npop; Inst_ready = 1'b1;
    feed(32'h3010);
    drain();
    chk("t6_restart_pops", npop - n0, 1);

    // Randomized traffic.
    lat_rand = 1; flush_prev = 0; Pc_valid = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      Imem_gnt   = ($urandom_range(0, 3) != 0);
      Inst_ready = ($urandom_range(0, 2) != 0);
      if (!Pc_valid || last_acc || flush_prev) begin
        Pc_valid = ($urandom_range(0, 4) != 0);
        Pc_in    = rand_pc();
      end
      Flush = ($urandom_range(0, 29) == 0);
      flush_prev = Flush;
      tick();
    end
    Imem_gnt = 1'b1;
    drain();
    chk("final_idle", Inst_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
